// File: rtl/miner_pkg.sv
// miner_pkg: shared widths, job layout and search states for the nonce search block
package miner_pkg;

    localparam int JOB_W                = 768;
    localparam int MIDSTATE_W           = 256;
    localparam int BLOCK_W              = 512;
    localparam int HASH_W               = 256;
    localparam int NONCE_W              = 32;
    localparam int NONCE_OFFSET_DEFAULT = 352;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        FOUND,
        EXHAUSTED
    } search_state_t;

    // Bit 0 of a job is the MSB of the midstate, matching the SPI receive order
    typedef struct packed {
        logic [0:MIDSTATE_W-1] midstate;
        logic [0:BLOCK_W-1]    block;
    } job_t;

    // Pull the nonce field out of a job; off is the job-relative index of the nonce MSB
    function automatic logic [NONCE_W-1:0] job_nonce(input job_t j, input int off);
        return j.block[off-MIDSTATE_W +: NONCE_W];
    endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// hash_target_cmp: flags a hash whose leading DIFF_ZERO_BITS bits (bit 0 upward) are all zero
module hash_target_cmp
    import miner_pkg::*;
#(
    parameter int DIFF_ZERO_BITS = 32
) (
    input  logic [0:HASH_W-1] i_hash,
    output logic              o_hit
);

    // Shifting the numeric value right leaves exactly the leading bits under test
    assign o_hit = (i_hash >> (HASH_W - DIFF_ZERO_BITS)) == '0;

endmodule

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: walks the job nonce through an external double-SHA256 core and latches the first hash meeting the leading-zero target.
// Build option: define NONCE_SEARCH_STATS_EN for a live saturating hash_count; otherwise hash_count is tied to 0.
module nonce_search_ctrl
    import miner_pkg::*;
#(
    parameter int DIFF_ZERO_BITS = 32,
    parameter int NONCE_OFFSET   = NONCE_OFFSET_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    input  logic [0:JOB_W-1]      job_data,
    output logic                  core_start,
    output logic [0:MIDSTATE_W-1] core_midstate,
    output logic [0:BLOCK_W-1]    core_block,
    input  logic                  core_done,
    input  logic [0:HASH_W-1]     core_hash,
    output logic [0:HASH_W-1]     result_hash,
    output logic [0:NONCE_W-1]    result_nonce,
    output logic                  found,
    output logic                  exhausted,
    output logic                  busy,
    output logic [31:0]           hash_count
);

    localparam int NB = NONCE_OFFSET - MIDSTATE_W;

    search_state_t         r_state;
    job_t                  r_shadow;
    logic                  r_pending;
    logic [0:MIDSTATE_W-1] r_midstate;
    logic [0:BLOCK_W-1]    r_block;
    logic [NONCE_W-1:0]    r_nonce;
    logic [0:HASH_W-1]     r_hash;
    logic                  r_start;
    logic [0:HASH_W-1]     r_result_hash;
    logic [NONCE_W-1:0]    r_result_nonce;

    job_t w_job;
    logic w_load;
    logic w_issue;
    logic w_stash;
    logic w_capture;
    logic w_check;
    logic w_hit;
    logic w_last;

    // Decode this cycle's transition; a live job_valid always beats the shadow copy
    always_comb begin
        w_job     = job_valid ? job_t'(job_data) : r_shadow;
        w_issue   = (r_state == ISSUE) && !job_valid;
        w_check   = (r_state == CHECK) && !job_valid;
        w_stash   = (r_state == WAIT) && !core_done && job_valid;
        w_capture = (r_state == WAIT) && core_done && !job_valid && !r_pending;
        w_load    = (r_state == WAIT) ? core_done && (job_valid || r_pending) : job_valid;
        w_last    = &r_nonce;
    end

    hash_target_cmp #(
        .DIFF_ZERO_BITS(DIFF_ZERO_BITS)
    ) u_cmp (
        .i_hash(r_hash),
        .o_hit (w_hit)
    );

    // Search FSM with job, nonce and captured-hash registers; core inputs only move outside WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_pending  <= 1'b0;
            r_shadow   <= '0;
            r_midstate <= '0;
            r_block    <= '0;
            r_nonce    <= '0;
            r_hash     <= '0;
        end else begin
            r_start   <= w_issue;
            r_pending <= w_load ? 1'b0 : (r_pending || w_stash);
            if (w_stash)
                r_shadow <= job_t'(job_data);
            if (w_capture)
                r_hash <= core_hash;
            if (w_load) begin
                r_midstate <= w_job.midstate;
                r_block    <= w_job.block;
                r_nonce    <= job_nonce(w_job, NONCE_OFFSET);
                r_state    <= ISSUE;
            end else if (w_issue) begin
                r_state <= WAIT;
            end else if (w_capture) begin
                r_state <= CHECK;
            end else if (w_check) begin
                r_state <= w_hit ? FOUND : (w_last ? EXHAUSTED : ISSUE);
                if (!w_hit && !w_last)
                    r_nonce <= r_nonce + 1'b1;
            end
        end
    end

    // Winning hash and nonce survive new jobs until the next hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result_hash  <= '0;
            r_result_nonce <= '0;
        end else if (w_check && w_hit) begin
            r_result_hash  <= r_hash;
            r_result_nonce <= r_nonce;
        end
    end

    // Overlay the current nonce onto the latched block 2
    always_comb begin
        core_block                = r_block;
        core_block[NB +: NONCE_W] = r_nonce;
    end

    assign core_start    = r_start;
    assign core_midstate = r_midstate;
    assign result_hash   = r_result_hash;
    assign result_nonce  = r_result_nonce;
    assign found         = r_state == FOUND;
    assign exhausted     = r_state == EXHAUSTED;
    assign busy          = (r_state == ISSUE) || (r_state == WAIT) || (r_state == CHECK);

`ifdef NONCE_SEARCH_STATS_EN
    logic [31:0] r_count;

    // Hashes checked for the current job, saturating at all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (w_load)
            r_count <= '0;
        else if (w_check && !(&r_count))
            r_count <= r_count + 1'b1;
    end

    assign hash_count = r_count;
`else
    assign hash_count = '0;
`endif

endmodule
